// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: first-word-fall-through queue of {pc, inst} pairs that
// decouples instruction fetch (IF) from decode (ID).
// - Requests an IF stall when full; drops all entries on a taken jump.
// - Optional statistics counters are built when INST_BUF_STATS_EN is defined;
//   otherwise the stats ports read as zero.
module inst_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush_i,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [DATA_W-1:0] if_inst_i,
  output logic              stallreq_o,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [15:0]       flush_cnt_o,
  output logic [15:0]       full_cyc_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  // Only stall[1] (hold ID) matters here; the other ctrl bits are ignored.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  // Status is decoded from registered state only, so stallreq_o has no
  // combinational path back from stall or if_valid_i.
  assign id_valid_o = (count != '0);
  assign stallreq_o = (count == FULL_CNT);

  // A flush cancels both sides; a full queue drops the incoming word even
  // when a pop frees a slot in the same cycle.
  assign push = if_valid_i & ~stallreq_o & ~flush_i;
  assign pop  = id_valid_o & ~stall[1] & ~flush_i;

  // Head entry falls through; an empty queue presents a NOP at pc 0.
  assign id_pc_o   = id_valid_o ? pc_mem[rd_ptr]   : '0;
  assign id_inst_o = id_valid_o ? inst_mem[rd_ptr] : '0;

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc_i;
      inst_mem[wr_ptr] <= if_inst_i;
    end
  end

  // Queue control: pointers wrap modulo DEPTH, count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef INST_BUF_STATS_EN
  logic [15:0] flush_cnt;
  logic [15:0] full_cyc_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics: non-empty flushes and full cycles, both saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt    <= '0;
      full_cyc_cnt <= '0;
    end else begin
      if (flush_i && id_valid_o) flush_cnt <= sat_inc16(flush_cnt);
      if (stallreq_o)            full_cyc_cnt <= sat_inc16(full_cyc_cnt);
    end
  end

  assign flush_cnt_o    = flush_cnt;
  assign full_cyc_cnt_o = full_cyc_cnt;
`else
  assign flush_cnt_o    = 16'h0;
  assign full_cyc_cnt_o = 16'h0;
`endif

endmodule
